// File: rtl/l80_io_pkg.sv
// Shared definitions for the light8080 io port bank: register offsets, edge modes,
// and the io-space address range check.
package l80_io_pkg;

    localparam logic [1:0] OFS_DATA  = 2'd0;
    localparam logic [1:0] OFS_DIR   = 2'd1;
    localparam logic [1:0] OFS_IEN   = 2'd2;
    localparam logic [1:0] OFS_IPEND = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    function automatic logic addr_in_range(input logic [7:0] addr, input int base,
                                           input int num_ports);
        int a;
        a = {24'd0, addr};
        return (a >= base) && (a < base + 4 * num_ports);
    endfunction

endpackage

// File: rtl/l80_io_port.sv
// One io port slice: DATA/DIR registers, pad synchroniser and, when
// L80_IO_PORT_INTR_EN is defined, edge detection with IEN/IPEND registers.
module l80_io_port
    import l80_io_pkg::*;
#(
    parameter int PORT_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int INT_EDGE    = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [1:0]        ofs,
    input  logic [7:0]        wdata,
    input  logic [PORT_W-1:0] pin_in,
    output logic [PORT_W-1:0] pin_out,
    output logic [PORT_W-1:0] pin_oe,
    output logic [7:0]        rdata,
    output logic              irq_req
);

    logic [PORT_W-1:0] sync_q [SYNC_STAGES];
    logic [PORT_W-1:0] pin_sync;
    logic [PORT_W-1:0] out_q;
    logic [PORT_W-1:0] oe_q;
    logic [PORT_W-1:0] ien_rd;
    logic [PORT_W-1:0] ipend_rd;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign pin_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= '0;
            oe_q  <= '0;
        end else if (wr_en) begin
            if (ofs == OFS_DATA) out_q <= wdata[PORT_W-1:0];
            if (ofs == OFS_DIR)  oe_q  <= wdata[PORT_W-1:0];
        end
    end

    assign pin_out = out_q;
    assign pin_oe  = oe_q;

`ifdef L80_IO_PORT_INTR_EN
    logic [PORT_W-1:0] dly_q;
    logic [PORT_W-1:0] ien_q;
    logic [PORT_W-1:0] ipend_q;
    logic [PORT_W-1:0] edge_hit;
    logic [PORT_W-1:0] w1c;

    always_comb begin
        edge_hit = pin_sync & ~dly_q;
        case (INT_EDGE)
            EDGE_FALL: edge_hit = ~pin_sync & dly_q;
            EDGE_BOTH: edge_hit = pin_sync ^ dly_q;
            default:   edge_hit = pin_sync & ~dly_q;
        endcase
    end

    assign w1c = (wr_en && ofs == OFS_IPEND) ? wdata[PORT_W-1:0] : '0;

    // A new edge is ORed in after the clear, so it survives a simultaneous W1C.
    always_ff @(posedge clock) begin
        if (reset) begin
            dly_q   <= '0;
            ien_q   <= '0;
            ipend_q <= '0;
        end else begin
            dly_q   <= pin_sync;
            ipend_q <= (ipend_q & ~w1c) | edge_hit;
            if (wr_en && ofs == OFS_IEN) ien_q <= wdata[PORT_W-1:0];
        end
    end

    assign ien_rd   = ien_q;
    assign ipend_rd = ipend_q;
    assign irq_req  = |(ipend_q & ien_q);
`else
    assign ien_rd   = '0;
    assign ipend_rd = '0;
    assign irq_req  = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_DATA:  rdata[PORT_W-1:0] = pin_sync;
            OFS_DIR:   rdata[PORT_W-1:0] = oe_q;
            OFS_IEN:   rdata[PORT_W-1:0] = ien_rd;
            default:   rdata[PORT_W-1:0] = ipend_rd;
        endcase
    end

endmodule

// File: rtl/l80_io_port_bank.sv
// Bank of NUM_PORTS bidirectional io ports on the light8080 io bus.
// Pin edge interrupts are built only when L80_IO_PORT_INTR_EN is defined.
module l80_io_port_bank
    import l80_io_pkg::*;
#(
    parameter int         NUM_PORTS   = 2,
    parameter int         PORT_W      = 8,
    parameter logic [7:0] BASE_ADDR   = 8'h84,
    parameter int         SYNC_STAGES = 2,
    parameter int         INT_EDGE    = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [7:0]                  io_addr,
    input  logic                        io_sel,
    input  logic                        io_wr,
    input  logic                        io_rd,
    input  logic [7:0]                  io_din,
    output logic [7:0]                  io_dout,
    output logic                        io_hit,
    input  logic [NUM_PORTS*PORT_W-1:0] pin_in,
    output logic [NUM_PORTS*PORT_W-1:0] pin_out,
    output logic [NUM_PORTS*PORT_W-1:0] pin_oe,
    output logic                        irq
);

    if ({24'd0, BASE_ADDR} + 4 * NUM_PORTS > 256) begin : g_range_err
        $error("l80_io_port_bank: BASE_ADDR + 4*NUM_PORTS exceeds the io space");
    end

    // Bus handshake: io_sel qualifies io_wr/io_rd; each strobe is acted on at the
    // single clock edge where it is high, with no wait states or backpressure.
    logic       sel_hit;
    logic [7:0] rel_addr;
    logic [5:0] port_idx;
    logic [1:0] reg_ofs;
    logic [7:0] rd_mux;
    logic [7:0] port_rdata [NUM_PORTS];
    logic [NUM_PORTS-1:0] port_irq;

    assign sel_hit  = io_sel & addr_in_range(io_addr, {24'd0, BASE_ADDR}, NUM_PORTS);
    assign rel_addr = io_addr - BASE_ADDR;
    assign port_idx = rel_addr[7:2];
    assign reg_ofs  = rel_addr[1:0];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic wr_en;
        assign wr_en = sel_hit & io_wr & (port_idx == 6'(p));

        l80_io_port #(
            .PORT_W      (PORT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .INT_EDGE    (INT_EDGE)
        ) u_port (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (wr_en),
            .ofs     (reg_ofs),
            .wdata   (io_din),
            .pin_in  (pin_in[p*PORT_W +: PORT_W]),
            .pin_out (pin_out[p*PORT_W +: PORT_W]),
            .pin_oe  (pin_oe[p*PORT_W +: PORT_W]),
            .rdata   (port_rdata[p]),
            .irq_req (port_irq[p])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_idx == 6'(p)) rd_mux = port_rdata[p];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            io_dout <= '0;
            io_hit  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            io_hit <= sel_hit;
            irq    <= |port_irq;
            if (sel_hit && io_rd) io_dout <= rd_mux;
        end
    end

endmodule

// File: tb/tb_l80_io_port_bank.sv
// Directed bench for l80_io_port_bank: a default 2x8 bank and a 1x5 bank at 0x40.
// Interrupt steps follow whether L80_IO_PORT_INTR_EN is defined for the build.
module tb_l80_io_port_bank;

    localparam int SYNC = 2;

    logic        clock;
    logic        reset;
    logic [7:0]  io_addr;
    logic        io_sel;
    logic        io_wr;
    logic        io_rd;
    logic [7:0]  io_din;
    logic [7:0]  io_dout;
    logic        io_hit;
    logic [15:0] pin_in;
    logic [15:0] pin_out;
    logic [15:0] pin_oe;
    logic        irq;

    logic [7:0]  io_dout5;
    logic        io_hit5;
    logic [4:0]  pin_in5;
    logic [4:0]  pin_out5;
    logic [4:0]  pin_oe5;
    logic        irq5;

    int checks = 0;
    int errors = 0;

    logic [7:0] rd_data;
    logic       rd_hit;

    l80_io_port_bank #(
        .NUM_PORTS(2), .PORT_W(8), .BASE_ADDR(8'h84), .SYNC_STAGES(SYNC), .INT_EDGE(0)
    ) dut (
        .clock(clock), .reset(reset), .io_addr(io_addr), .io_sel(io_sel),
        .io_wr(io_wr), .io_rd(io_rd), .io_din(io_din), .io_dout(io_dout),
        .io_hit(io_hit), .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe),
        .irq(irq)
    );

    l80_io_port_bank #(
        .NUM_PORTS(1), .PORT_W(5), .BASE_ADDR(8'h40), .SYNC_STAGES(SYNC), .INT_EDGE(0)
    ) dut5 (
        .clock(clock), .reset(reset), .io_addr(io_addr), .io_sel(io_sel),
        .io_wr(io_wr), .io_rd(io_rd), .io_din(io_din), .io_dout(io_dout5),
        .io_hit(io_hit5), .pin_in(pin_in5), .pin_out(pin_out5), .pin_oe(pin_oe5),
        .irq(irq5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Tasks are entered just after a falling edge; the strobe spans one rising edge.
    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        io_addr = addr;
        io_din  = data;
        io_sel  = 1'b1;
        io_wr   = 1'b1;
        @(negedge clock);
        io_sel  = 1'b0;
        io_wr   = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data,
                            output logic hit);
        io_addr = addr;
        io_sel  = 1'b1;
        io_rd   = 1'b1;
        @(negedge clock);
        io_sel  = 1'b0;
        io_rd   = 1'b0;
        data    = io_dout;
        hit     = io_hit;
    endtask

    initial begin
        reset   = 1'b1;
        io_addr = 8'h00;
        io_sel  = 1'b0;
        io_wr   = 1'b0;
        io_rd   = 1'b0;
        io_din  = 8'h00;
        pin_in  = 16'h0000;
        pin_in5 = 5'h00;
        repeat (3) @(negedge clock);
        check("reset_pin_out", 32'(pin_out), 32'h0);
        check("reset_pin_oe", 32'(pin_oe), 32'h0);
        check("reset_io_dout", 32'(io_dout), 32'h0);
        check("reset_io_hit", 32'(io_hit), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        @(negedge clock);

        for (int a = 0; a < 8; a++) begin
            bus_read(8'(8'h84 + a), rd_data, rd_hit);
            check($sformatf("default_read_%0d", a), 32'(rd_data), 32'h0);
            check($sformatf("default_hit_%0d", a), 32'(rd_hit), 32'h1);
        end
        check("default_irq", 32'(irq), 32'h0);

        bus_write(8'h85, 8'hF0);
        bus_write(8'h84, 8'hA5);
        check("dir0_pin_oe", 32'(pin_oe[7:0]), 32'hF0);
        check("data0_pin_out", 32'(pin_out[7:0]), 32'hA5);
        check("port1_pin_out", 32'(pin_out[15:8]), 32'h00);
        pin_in[7:0] = 8'h3C;
        repeat (SYNC + 1) @(negedge clock);
        bus_read(8'h84, rd_data, rd_hit);
        check("data0_sync_read", 32'(rd_data), 32'h3C);
        bus_read(8'h85, rd_data, rd_hit);
        check("dir0_read", 32'(rd_data), 32'hF0);

        bus_read(8'h83, rd_data, rd_hit);
        check("below_range_hit", 32'(rd_hit), 32'h0);
        check("below_range_dout", 32'(rd_data), 32'hF0);
        bus_read(8'h8C, rd_data, rd_hit);
        check("above_range_hit", 32'(rd_hit), 32'h0);
        check("above_range_dout", 32'(rd_data), 32'hF0);
        check("above_range_dir0", 32'(pin_oe[7:0]), 32'hF0);

        bus_write(8'h40, 8'hFF);
        bus_write(8'h41, 8'hFF);
        check("w5_pin_out", 32'(pin_out5), 32'h1F);
        check("w5_pin_oe", 32'(pin_oe5), 32'h1F);
        check("w5_main_untouched", 32'(pin_out[7:0]), 32'hA5);
        pin_in5 = 5'h1F;
        repeat (SYNC + 1) @(negedge clock);
        bus_read(8'h40, rd_data, rd_hit);
        check("w5_data_read", 32'(io_dout5), 32'h1F);
        check("w5_hit", 32'(io_hit5), 32'h1);
        check("w5_main_no_hit", 32'(rd_hit), 32'h0);
        bus_read(8'h41, rd_data, rd_hit);
        check("w5_dir_read", 32'(io_dout5), 32'h1F);

`ifdef L80_IO_PORT_INTR_EN
        bus_write(8'h8A, 8'h01);
        bus_read(8'h8A, rd_data, rd_hit);
        check("ien1_read", 32'(rd_data), 32'h01);
        pin_in[8] = 1'b1;
        repeat (5) @(negedge clock);
        bus_read(8'h8B, rd_data, rd_hit);
        check("ipend1_set", 32'(rd_data), 32'h01);
        check("irq_set", 32'(irq), 32'h1);
        bus_write(8'h8B, 8'h01);
        check("irq_before_clear", 32'(irq), 32'h1);
        @(negedge clock);
        check("irq_after_clear", 32'(irq), 32'h0);
        bus_read(8'h8B, rd_data, rd_hit);
        check("ipend1_cleared", 32'(rd_data), 32'h00);

        pin_in[8] = 1'b0;
        repeat (4) @(negedge clock);
        check("falling_no_irq", 32'(irq), 32'h0);
        pin_in[8] = 1'b1;
        repeat (5) @(negedge clock);
        check("second_rise_irq", 32'(irq), 32'h1);
        pin_in[8] = 1'b0;
        repeat (4) @(negedge clock);
        pin_in[8] = 1'b1;
        repeat (2) @(negedge clock);
        bus_write(8'h8B, 8'h01);
        check("set_wins_irq_now", 32'(irq), 32'h1);
        @(negedge clock);
        check("set_wins_irq_later", 32'(irq), 32'h1);
        bus_read(8'h8B, rd_data, rd_hit);
        check("set_wins_ipend", 32'(rd_data), 32'h01);
        bus_write(8'h8B, 8'h01);
        @(negedge clock);
        check("final_clear_irq", 32'(irq), 32'h0);
`else
        bus_write(8'h8A, 8'h01);
        bus_read(8'h8A, rd_data, rd_hit);
        check("ien1_ignored", 32'(rd_data), 32'h00);
        check("ien1_hit", 32'(rd_hit), 32'h1);
        pin_in[8] = 1'b1;
        repeat (5) @(negedge clock);
        check("irq_tied_low", 32'(irq), 32'h0);
        bus_read(8'h8B, rd_data, rd_hit);
        check("ipend1_reads_zero", 32'(rd_data), 32'h00);
`endif

        pin_in = 16'h0000;
        repeat (4) @(negedge clock);
        io_addr = 8'h84;
        io_din  = 8'h77;
        io_sel  = 1'b1;
        io_wr   = 1'b1;
        reset   = 1'b1;
        @(negedge clock);
        io_sel  = 1'b0;
        io_wr   = 1'b0;
        reset   = 1'b0;
        check("reset_abort_pin_out", 32'(pin_out[7:0]), 32'h00);
        check("reset_abort_pin_oe", 32'(pin_oe[7:0]), 32'h00);
        check("reset_abort_hit", 32'(io_hit), 32'h0);
        @(negedge clock);
        check("post_reset_irq", 32'(irq), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
